alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared ALU.
// Latches the winner's operands, waits for a low-then-high alu_done or times out, then acks.
module alu_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        err0,
    output logic        err1,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    // Counter value on the final permitted WAIT cycle.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        win_q, win_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        seen_low_q, seen_low_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        err_q, err_d;
    logic        grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            win_q      <= 1'b0;
            op_q       <= 3'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            seen_low_q <= 1'b0;
            cnt_q      <= 8'd0;
            res_q      <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            win_q      <= win_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            seen_low_q <= seen_low_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        err_d      = err_q;
        grant      = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        res0       = 16'd0;
        res1       = 16'd0;
        err0       = 1'b0;
        err1       = 1'b0;
        alu_a      = 8'd0;
        alu_b      = 8'd0;
        alu_op     = 3'd0;
        alu_start  = 1'b0;
        busy       = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // A lone request wins outright; a tie goes to the rr pointer.
                    grant   = (req0 && req1) ? rr_q : req1;
                    win_d   = grant;
                    rr_d    = ~grant;
                    op_d    = grant ? op1 : op0;
                    a_d     = grant ? a1 : a0;
                    b_d     = grant ? b1 : b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                alu_start  = 1'b1;
                alu_op     = op_q;
                alu_a      = a_q;
                alu_b      = b_q;
                seen_low_d = 1'b0;
                cnt_d      = 8'd0;
                state_d    = StWait;
            end
            StWait: begin
                alu_start = 1'b1;
                alu_op    = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                if (!alu_done) begin
                    seen_low_d = 1'b1;
                end
                // A done that was never preceded by a low is the ALU's idle level.
                if (alu_done && seen_low_q) begin
                    res_d   = alu_result;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == TmoLast) begin
                    res_d   = 16'd0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                if (win_q) begin
                    ack1 = 1'b1;
                    res1 = res_q;
                    err1 = err_q;
                end else begin
                    ack0 = 1'b1;
                    res0 = res_q;
                    err0 = err_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences and a
// randomized run scored against a transaction-level round-robin model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1;
    logic [15:0] res0, res1;
    logic        err0, err1;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b1;
    logic [15:0] alu_result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // ALU model knobs: low cycles before done, stale high first, or never complete.
    int lat_m   = 2;
    bit stale_m = 1'b0;
    bit hang_m  = 1'b0;
    int k_m     = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .ack0       (ack0),
        .ack1       (ack1),
        .res0       (res0),
        .res1       (res1),
        .err0       (err0),
        .err1       (err1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy)
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return 16'(a) - 16'(b);
            3'd3:    return 16'(a) * 16'(b);
            3'd4:    return {8'h00, a & b};
            3'd5:    return {a, b};
            3'd6:    return {b, a};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    // k_m counts cycles of the current alu_start burst (1 = ISSUE, 2 = first WAIT).
    always @(negedge clk) begin
        if (reset || !alu_start) k_m = 0;
        else k_m = k_m + 1;
        if (k_m <= 1) alu_done = 1'b1;
        else if (hang_m) alu_done = 1'b0;
        else if (stale_m && k_m == 2) alu_done = 1'b1;
        else alu_done = (k_m >= 2 + int'(stale_m) + lat_m);
    end

    function automatic logic [63:0] outs();
        return {7'd0, ack0, ack1, res0, res1, err0, err1, alu_a, alu_b, alu_op, alu_start, busy};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        check("reset_outs", outs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise one request, wait for an ack (bounded), optionally corrupt inputs after issue.
    task automatic run_txn(input int who, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input bit mangle, output logic [15:0] res,
                           output logic err, output int starts, output int acked);
        bit mangled = 1'b0;
        starts = 0;
        acked  = -1;
        res    = 16'd0;
        err    = 1'b0;
        if (who == 0) begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
        else begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (alu_start) starts++;
            if (mangle && alu_start && !mangled) begin
                mangled = 1'b1;
                if (who == 0) begin op0 = ~op; a0 = ~a; b0 = ~b; end
                else begin op1 = ~op; a1 = ~a; b1 = ~b; end
            end
            if (ack0 || ack1) begin
                acked = ack0 ? 0 : 1;
                res   = ack0 ? res0 : res1;
                err   = ack0 ? err0 : err1;
                break;
            end
        end
        if (who == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[9];
        logic [15:0] r;
        logic        e;
        int          st, who;

        {op0, op1, a0, b0, a1, b1} = '0;
        do_reset();
        check("post_reset_outs", outs(), 64'd0);

        vecs[0] = '{3'd1, 8'h23, 8'h23, 16'h0046};
        vecs[1] = '{3'd2, 8'h10, 8'h01, 16'h000F};
        vecs[2] = '{3'd3, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{3'd4, 8'hF0, 8'h3C, 16'h0030};
        vecs[4] = '{3'd5, 8'h12, 8'h34, 16'h1234};
        vecs[5] = '{3'd6, 8'h12, 8'h34, 16'h3412};
        vecs[6] = '{3'd0, 8'hAA, 8'h55, 16'h0000};
        vecs[7] = '{3'd7, 8'hAA, 8'h55, 16'h0000};
        vecs[8] = '{3'd2, 8'h00, 8'h01, 16'hFFFF};

        for (int i = 0; i < 9; i++) begin
            run_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r, e, st, who);
            check($sformatf("vec%0d_who", i), who, 0);
            check($sformatf("vec%0d_res", i), r, vecs[i].exp);
            check($sformatf("vec%0d_err", i), e, 0);
            check($sformatf("vec%0d_starts", i), st, 4);
            @(negedge clk);
            check($sformatf("vec%0d_ack_pulse", i), {ack0, ack1, busy}, 0);
        end

        // Operands changed after latching must not leak into the result.
        run_txn(1, 3'd4, 8'hF0, 8'h3C, 1'b1, r, e, st, who);
        check("mangle_who", who, 1);
        check("mangle_res", r, 16'h0030);

        // Stale idle-done on the first WAIT cycle must be ignored.
        stale_m = 1'b1;
        lat_m   = 1;
        run_txn(0, 3'd1, 8'h01, 8'h02, 1'b0, r, e, st, who);
        check("stale_res", r, 16'h0003);
        check("stale_starts", st, 4);
        stale_m = 1'b0;
        lat_m   = 2;

        // Timeout: 1 ISSUE + 15 WAIT cycles, then errored ack, then a normal transaction.
        hang_m = 1'b1;
        run_txn(1, 3'd3, 8'h07, 8'h09, 1'b0, r, e, st, who);
        check("tmo_who", who, 1);
        check("tmo_starts", st, 16);
        check("tmo_err", e, 1);
        check("tmo_res", r, 16'h0000);
        hang_m = 1'b0;
        run_txn(1, 3'd3, 8'h07, 8'h09, 1'b0, r, e, st, who);
        check("post_tmo_res", r, 16'h003F);
        check("post_tmo_err", e, 0);

        // Simultaneous requests after reset: 0 first, then strict alternation.
        do_reset();
        begin
            int order[4];
            logic [15:0] rv[4];
            int n = 0;
            op0 = 3'd1; a0 = 8'h11; b0 = 8'h22;
            op1 = 3'd3; a1 = 8'h03; b1 = 8'h04;
            req0 = 1'b1;
            req1 = 1'b1;
            for (int i = 0; i < 200 && n < 4; i++) begin
                @(negedge clk);
                if (ack0 || ack1) begin
                    order[n] = ack0 ? 0 : 1;
                    rv[n]    = ack0 ? res0 : res1;
                    n++;
                end
            end
            req0 = 1'b0;
            req1 = 1'b0;
            check("pair_ack_count", n, 4);
            for (int i = 0; i < n; i++) begin
                check($sformatf("pair_order%0d", i), order[i], i % 2);
                check($sformatf("pair_res%0d", i), rv[i], (i % 2 == 0) ? 16'h0033 : 16'h000C);
            end
        end

        // Asynchronous reset in WAIT aborts without ack; held request is served afresh.
        @(negedge clk);
        hang_m = 1'b1;
        op0 = 3'd1; a0 = 8'h05; b0 = 8'h06; req0 = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy", {busy, alu_start}, 2'b11);
        #2 reset = 1'b1;
        #1 check("async_reset_outs", outs(), 64'd0);
        hang_m = 1'b0;
        @(negedge clk);
        check("held_reset_outs", outs(), 64'd0);
        reset = 1'b0;
        #1 check("idle_on_release", busy, 0);
        run_txn(0, 3'd1, 8'h05, 8'h06, 1'b0, r, e, st, who);
        check("rereq_who", who, 0);
        check("rereq_res", r, 16'h000B);
        check("rereq_err", e, 0);

        // Randomized traffic against a transaction-level round-robin model.
        do_reset();
        begin
            logic [2:0] rop[2];
            logic [7:0] ra[2], rb[2];
            bit         rq[2];
            int         age[2];
            int         exp_q[$];
            bit         rr_m = 1'b0;
            int         done = 0;
            int         w;
            rq = '{1'b0, 1'b0};
            age = '{0, 0};
            for (int cyc = 0; cyc < 4000 && done < 150; cyc++) begin
                @(negedge clk);
                if (ack0 && ack1) check("rnd_dual_ack", 1, 0);
                for (int q = 0; q < 2; q++) begin
                    if ((q == 0) ? ack0 : ack1) begin
                        if (exp_q.size() == 0) check("rnd_unexpected_ack", q, 99);
                        else begin
                            w = exp_q.pop_front();
                            check("rnd_winner", q, w);
                        end
                        check("rnd_res", (q == 0) ? res0 : res1, alu_fn(rop[q], ra[q], rb[q]));
                        check("rnd_err", (q == 0) ? err0 : err1, 0);
                        done++;
                        rq[q]  = 1'($urandom_range(0, 1));
                        rop[q] = 3'($urandom_range(0, 7));
                        ra[q]  = 8'($urandom);
                        rb[q]  = 8'($urandom);
                        age[q] = 0;
                    end
                end
                for (int q = 0; q < 2; q++) begin
                    if (rq[q]) begin
                        age[q]++;
                        if (age[q] > 100) begin
                            check("rnd_starved", q, 99);
                            rq[q]  = 1'b0;
                            age[q] = 0;
                        end
                    end else if ($urandom_range(0, 3) == 0) begin
                        rq[q]  = 1'b1;
                        rop[q] = 3'($urandom_range(0, 7));
                        ra[q]  = 8'($urandom);
                        rb[q]  = 8'($urandom);
                        age[q] = 0;
                    end
                end
                if (!alu_start) begin
                    lat_m   = $urandom_range(1, 6);
                    stale_m = 1'($urandom_range(0, 1));
                end
                req0 = rq[0]; op0 = rop[0]; a0 = ra[0]; b0 = rb[0];
                req1 = rq[1]; op1 = rop[1]; a1 = ra[1]; b1 = rb[1];
                if (!busy && (rq[0] || rq[1])) begin
                    w = (rq[0] && rq[1]) ? int'(rr_m) : (rq[1] ? 1 : 0);
                    exp_q.push_back(w);
                    rr_m = (w == 0);
                end
            end
            check("rnd_done_enough", done >= 150, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
